// File: rtl/lcd_defs.sv
// Shared definitions for the HD44780-style LCD refresh controller:
// FSM encodings, command bytes and small constant helpers.
package lcd_defs;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETADDR,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PHY_IDLE,
        PHY_SETUP,
        PHY_PULSE,
        PHY_WAIT
    } phy_state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // Write slots within a refresh: 0 = line-1 address, 17 = line-2 address.
    localparam logic [5:0] LINE2_WR = 6'd17;
    localparam logic [5:0] LAST_WR  = 6'd33;
    localparam logic [2:0] N_INIT   = 3'd4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_wr_phy.sv
// Single LCD bus write: setup with E low, E pulse, then a post-write wait.
// Accepts a request only while o_ready is high; RS/DB hold until the next write.
module lcd_wr_phy
    import lcd_defs::*;
#(
    parameter int T_AS   = 4,
    parameter int T_PW   = 12,
    parameter int T_WAIT = 2000,
    parameter int T_CLR  = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long_wait,
    output logic       o_ready,
    output logic       o_lcd_rs,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db
);

    localparam int CW = $clog2(max2(max2(T_AS, T_PW), max2(T_WAIT, T_CLR)) + 1);
    localparam logic [CW-1:0] AS_LAST   = CW'(T_AS - 1);
    localparam logic [CW-1:0] PW_LAST   = CW'(T_PW - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(T_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(T_CLR - 1);

    phy_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_long;
    logic          r_ready;
    logic          r_rs;
    logic          r_e;
    logic [7:0]    r_db;
    logic [CW-1:0] w_wait_last;

    assign w_wait_last = r_long ? CLR_LAST : WAIT_LAST;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= PHY_IDLE;
            r_cnt   <= '0;
            r_long  <= 1'b0;
            r_ready <= 1'b1;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_db    <= 8'h00;
        end else begin
            unique case (r_state)
                PHY_IDLE: begin
                    if (i_req && r_ready) begin
                        r_rs    <= i_rs;
                        r_db    <= i_data;
                        r_long  <= i_long_wait;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= PHY_SETUP;
                    end
                end
                PHY_SETUP: begin
                    if (r_cnt == AS_LAST) begin
                        r_cnt   <= '0;
                        r_e     <= 1'b1;
                        r_state <= PHY_PULSE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PHY_PULSE: begin
                    if (r_cnt == PW_LAST) begin
                        r_cnt   <= '0;
                        r_e     <= 1'b0;
                        r_state <= PHY_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PHY_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= PHY_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= PHY_IDLE;
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_lcd_rs = r_rs;
    assign o_lcd_e  = r_e;
    assign o_lcd_db = r_db;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// LCD refresh controller: power-up wait, 4-command init, then on request
// rewrites both 16-char lines from an external 32-byte string memory.
module lcd_refresh_ctrl
    import lcd_defs::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_AS    = 4,
    parameter int T_PW    = 12,
    parameter int T_WAIT  = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic [4:0] o_char_addr,
    input  logic [7:0] i_char_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = $clog2(max2(T_PWRUP, T_CLR) + 1);
    localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);

    ctrl_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_init_idx;
    logic [5:0]    r_wr_idx;
    logic [4:0]    r_char_idx;
    logic [4:0]    r_char_addr;
    logic          r_pending;
    logic          r_busy;
    logic          r_done;
    logic          r_rw;

    logic          w_ready;
    logic          w_req;
    logic          w_rs;
    logic [7:0]    w_data;
    logic          w_long;
    logic          w_cmd_slot;

    assign w_cmd_slot = (r_wr_idx == 6'd0) || (r_wr_idx == LINE2_WR);

    // Request is combinational so the PHY latches char_data at the end of FETCH.
    always_comb begin
        w_req  = 1'b0;
        w_rs   = 1'b0;
        w_data = 8'h00;
        case (r_state)
            ST_INIT: begin
                if (w_ready && r_init_idx != N_INIT) begin
                    w_req  = 1'b1;
                    w_data = init_cmd(r_init_idx[1:0]);
                end
            end
            ST_SETADDR: begin
                if (w_ready && w_cmd_slot) begin
                    w_req  = 1'b1;
                    w_data = (r_wr_idx == 6'd0) ? CMD_LINE1 : CMD_LINE2;
                end
            end
            ST_FETCH: begin
                w_req  = w_ready;
                w_rs   = 1'b1;
                w_data = i_char_data;
            end
            default: ;
        endcase
        w_long = !w_rs && (w_data == CMD_CLEAR);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= '0;
            r_init_idx  <= '0;
            r_wr_idx    <= '0;
            r_char_idx  <= '0;
            r_char_addr <= '0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_rw        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rw   <= 1'b0;
            if (i_start && r_state != ST_IDLE && r_state != ST_DONE) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == PWRUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_INIT: begin
                    if (w_ready) begin
                        if (r_init_idx == N_INIT) begin
                            r_state <= ST_IDLE;
                            r_busy  <= r_pending || i_start;
                        end else begin
                            r_init_idx <= r_init_idx + 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (i_start || r_pending) begin
                        r_pending  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wr_idx   <= '0;
                        r_char_idx <= '0;
                        r_state    <= ST_SETADDR;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SETADDR: begin
                    if (w_ready) begin
                        if (w_cmd_slot) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_char_addr <= r_char_idx;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_char_addr <= '0;
                    if (r_char_idx != 5'd31) begin
                        r_char_idx <= r_char_idx + 5'd1;
                    end
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (w_ready) begin
                        if (r_wr_idx == LAST_WR) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_wr_idx <= r_wr_idx + 6'd1;
                            r_state  <= ST_SETADDR;
                        end
                    end
                end
                ST_DONE: begin
                    if (r_pending || i_start) begin
                        r_pending  <= 1'b0;
                        r_wr_idx   <= '0;
                        r_char_idx <= '0;
                        r_state    <= ST_SETADDR;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_PWRUP;
            endcase
        end
    end

    lcd_wr_phy #(
        .T_AS   (T_AS),
        .T_PW   (T_PW),
        .T_WAIT (T_WAIT),
        .T_CLR  (T_CLR)
    ) u_phy (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (w_req),
        .i_rs        (w_rs),
        .i_data      (w_data),
        .i_long_wait (w_long),
        .o_ready     (w_ready),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_e     (o_lcd_e),
        .o_lcd_db    (o_lcd_db)
    );

    assign o_char_addr = r_char_addr;
    assign o_lcd_rw    = r_rw;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: bus monitor records every E pulse, tasks compare
// the recorded write stream and timing against a list-based model of the display.
`timescale 1ns/1ps
module tb_lcd_refresh_ctrl;

    localparam int T_PWRUP = 10;
    localparam int T_AS    = 1;
    localparam int T_PW    = 2;
    localparam int T_WAIT  = 3;
    localparam int T_CLR   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy, done;
    logic [7:0] lcd_db;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         setup;
        int         pw;
        int         gap;
        logic       hold_ok;
        logic [7:0] fetch;
        int         rise_cyc;
        int         fall_cyc;
    } wr_t;
    typedef struct {
        logic       rs;
        logic [7:0] db;
    } exp_t;

    wr_t        wq[$];
    exp_t       exp_q[$];
    int         addr_q[$];
    wr_t        cur;
    logic [7:0] mem [32];
    logic [7:0] hist [4096];
    logic [7:0] rnd_val = 8'h00;
    bit         rand_mode = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_high = 0, done_rises = 0, busy_low = 0, rw_bad = 0, rise_cnt = 0;
    int         low_cnt = 0, high_cnt = 0, stable_cnt = 0;
    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_db = 8'h00;

    lcd_refresh_ctrl #(
        .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_PW(T_PW), .T_WAIT(T_WAIT), .T_CLR(T_CLR)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_char_addr(char_addr), .i_char_data(char_data),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_e(lcd_e), .o_lcd_db(lcd_db),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random character source: a fresh byte every cycle, logged by cycle number.
    always @(posedge clk) begin
        #1;
        rnd_val = 8'($urandom);
        hist[cyc & 4095] = rnd_val;
    end

    always_comb char_data = rand_mode ? rnd_val : mem[char_addr];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0; prev_done = 1'b0; low_cnt = 0; stable_cnt = 0;
        end else begin
            if (lcd_rs === prev_rs && lcd_db === prev_db) stable_cnt++;
            else stable_cnt = 1;
            if (lcd_e && !prev_e) begin
                cur.rs = lcd_rs; cur.db = lcd_db; cur.setup = stable_cnt - 1;
                cur.gap = low_cnt; cur.hold_ok = 1'b1; cur.rise_cyc = cyc;
                cur.fetch = hist[(cyc - T_AS - 1) & 4095];
                high_cnt = 1; rise_cnt++;
            end else if (lcd_e) begin
                high_cnt++;
                if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.hold_ok = 1'b0;
            end else if (prev_e) begin
                cur.pw = high_cnt; cur.fall_cyc = cyc;
                wq.push_back(cur);
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            if (done) begin
                done_high++;
                if (!prev_done) done_rises++;
            end
            if (!busy) busy_low++;
            if (lcd_rw !== 1'b0) rw_bad++;
            if (char_addr != 5'd0) addr_q.push_back(int'(char_addr));
            prev_e = lcd_e; prev_rs = lcd_rs; prev_db = lcd_db; prev_done = done;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        wq.delete(); exp_q.delete(); addr_q.delete();
        done_high = 0; done_rises = 0; busy_low = 0; rw_bad = 0; rise_cnt = 0;
    endtask

    task automatic model_init();
        exp_q.push_back('{1'b0, 8'h38});
        exp_q.push_back('{1'b0, 8'h0C});
        exp_q.push_back('{1'b0, 8'h06});
        exp_q.push_back('{1'b0, 8'h01});
    endtask

    task automatic model_refresh();
        exp_q.push_back('{1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, mem[i]});
        exp_q.push_back('{1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back('{1'b1, mem[i]});
    endtask

    // Number of recorded writes whose RS/DB differ from the model.
    function automatic int stream_errs(input bit use_fetch);
        int errs = 0;
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            logic [7:0] want;
            want = (use_fetch && exp_q[i].rs) ? wq[i].fetch : exp_q[i].db;
            if (wq[i].rs !== exp_q[i].rs || wq[i].db !== want) errs++;
        end
        return errs;
    endfunction

    function automatic int timing_errs();
        int errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            int need_gap;
            need_gap = T_AS + ((i > 0 && wq[i-1].rs == 1'b0 && wq[i-1].db == 8'h01) ? T_CLR : T_WAIT);
            if (wq[i].pw != T_PW || !wq[i].hold_ok || wq[i].setup < T_AS || wq[i].gap < need_gap) errs++;
        end
        return errs;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) tick();
        n_checks++; if (lcd_e !== 1'b0) $display("FAIL reset_e: got %b want 0", lcd_e); else n_pass++;
        n_checks++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", lcd_rs); else n_pass++;
        n_checks++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", lcd_rw); else n_pass++;
        n_checks++; if (lcd_db !== 8'h00) $display("FAIL reset_db: got %h want 00", lcd_db); else n_pass++;
        n_checks++; if (char_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", char_addr); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        $display("test_reset: outputs checked under reset");
    endtask

    // Releases reset and checks the power-up delay, the 4 init commands and busy fall.
    task automatic test_init(input string tag);
        int rel_cyc, k, dt, errs;
        clear_logs();
        model_init();
        rst_n = 1'b1;
        rel_cyc = cyc;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin tick(); k++; end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_busy_fall: busy still %b after %0d cycles", tag, busy, k);
        else n_pass++;
        n_checks++;
        if (wq.size() != 4) $display("FAIL %s_count: got %0d writes want 4", tag, wq.size());
        else n_pass++;
        errs = stream_errs(1'b0);
        n_checks++;
        if (errs != 0) $display("FAIL %s_cmds: got %0d wrong writes want 0", tag, errs); else n_pass++;
        errs = timing_errs();
        n_checks++;
        if (errs != 0) $display("FAIL %s_timing: got %0d bad writes want 0", tag, errs); else n_pass++;
        if (wq.size() == 4) begin
            dt = wq[0].rise_cyc - rel_cyc;
            n_checks++;
            if (dt < T_PWRUP || dt > T_PWRUP + T_AS + 4)
                $display("FAIL %s_pwrup: first E after %0d cycles want %0d..%0d", tag, dt, T_PWRUP, T_PWRUP + T_AS + 4);
            else n_pass++;
            dt = cyc - wq[3].fall_cyc;
            n_checks++;
            if (dt < T_CLR || dt > T_CLR + 4)
                $display("FAIL %s_clr_gap: busy fell %0d cycles after clear want %0d..%0d", tag, dt, T_CLR, T_CLR + 4);
            else n_pass++;
        end
        $display("%s: %0d writes, busy low at cycle %0d", tag, wq.size(), cyc);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_rises < n && k < budget) begin tick(); k++; end
        n_checks++;
        if (done_rises < n) $display("FAIL %s_timeout: done pulses %0d want %0d", tag, done_rises, n);
        else n_pass++;
    endtask

    task automatic test_refresh();
        int errs;
        clear_logs();
        model_refresh();
        pulse_start();
        wait_done(1, 3000, "refresh");
        repeat (40) tick();
        n_checks++; if (wq.size() != 34) $display("FAIL refresh_count: got %0d writes want 34", wq.size()); else n_pass++;
        errs = stream_errs(1'b0);
        n_checks++; if (errs != 0) $display("FAIL refresh_data: got %0d wrong writes want 0", errs); else n_pass++;
        errs = timing_errs();
        n_checks++; if (errs != 0) $display("FAIL refresh_timing: got %0d bad writes want 0", errs); else n_pass++;
        n_checks++;
        if (done_rises != 1 || done_high != 1)
            $display("FAIL refresh_done: pulses %0d high cycles %0d want 1 and 1", done_rises, done_high);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i + 1) errs++;
        n_checks++;
        if (addr_q.size() != 31 || errs != 0)
            $display("FAIL refresh_addr: %0d nonzero addrs, %0d out of order, want 31 and 0", addr_q.size(), errs);
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL refresh_idle: busy %b want 0", busy); else n_pass++;
        $display("test_refresh: %0d writes, %0d done pulses", wq.size(), done_rises);
    endtask

    task automatic test_back_to_back();
        int k, errs, low_at_done;
        clear_logs();
        model_refresh();
        model_refresh();
        pulse_start();
        busy_low = 0;
        k = 0;
        while (wq.size() < 5 && k < 500) begin tick(); k++; end
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(1, 30)) tick();
            pulse_start();
        end
        wait_done(2, 6000, "b2b");
        low_at_done = busy_low;
        repeat (200) tick();
        n_checks++; if (wq.size() != 68) $display("FAIL b2b_count: got %0d writes want 68", wq.size()); else n_pass++;
        errs = stream_errs(1'b0);
        n_checks++; if (errs != 0) $display("FAIL b2b_data: got %0d wrong writes want 0", errs); else n_pass++;
        n_checks++; if (done_rises != 2) $display("FAIL b2b_done: got %0d pulses want 2", done_rises); else n_pass++;
        n_checks++; if (low_at_done != 0) $display("FAIL b2b_busy_gap: busy low %0d cycles want 0", low_at_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: busy %b want 0", busy); else n_pass++;
        $display("test_back_to_back: %0d writes, %0d done pulses", wq.size(), done_rises);
    endtask

    task automatic test_fetch_sample();
        int errs;
        clear_logs();
        model_refresh();
        rand_mode = 1'b1;
        pulse_start();
        wait_done(1, 3000, "fetch");
        repeat (10) tick();
        rand_mode = 1'b0;
        n_checks++; if (wq.size() != 34) $display("FAIL fetch_count: got %0d writes want 34", wq.size()); else n_pass++;
        errs = stream_errs(1'b1);
        n_checks++; if (errs != 0) $display("FAIL fetch_data: got %0d bytes not from fetch cycle want 0", errs); else n_pass++;
        n_checks++; if (rw_bad != 0) $display("FAIL fetch_rw: rw high %0d cycles want 0", rw_bad); else n_pass++;
        $display("test_fetch_sample: %0d writes with toggling char_data", wq.size());
    endtask

    task automatic test_reset_mid_write();
        int k = 0;
        clear_logs();
        pulse_start();
        while (!(rise_cnt == 9 && lcd_e === 1'b1) && k < 2000) begin tick(); k++; end
        n_checks++;
        if (lcd_db !== mem[7] || lcd_e !== 1'b1)
            $display("FAIL midrst_setup: e %b db %h want 1 and %h", lcd_e, lcd_db, mem[7]);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (lcd_e !== 1'b0) $display("FAIL midrst_e: got %b want 0", lcd_e); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else n_pass++;
        tick();
        test_init("midrst_init");
        repeat (60) tick();
        n_checks++; if (wq.size() != 4) $display("FAIL midrst_no_refresh: got %0d writes want 4", wq.size()); else n_pass++;
    endtask

    task automatic test_start_in_pwrup();
        int errs;
        rst_n = 1'b0;
        repeat (3) tick();
        clear_logs();
        model_init();
        model_refresh();
        rst_n = 1'b1;
        repeat (3) tick();
        pulse_start();
        repeat (12) tick();
        pulse_start();
        wait_done(1, 4000, "pwrup_start");
        repeat (150) tick();
        n_checks++; if (wq.size() != 38) $display("FAIL pwrup_start_count: got %0d writes want 38", wq.size()); else n_pass++;
        errs = stream_errs(1'b0);
        n_checks++; if (errs != 0) $display("FAIL pwrup_start_data: got %0d wrong writes want 0", errs); else n_pass++;
        errs = timing_errs();
        n_checks++; if (errs != 0) $display("FAIL pwrup_start_timing: got %0d bad writes want 0", errs); else n_pass++;
        n_checks++; if (done_rises != 1) $display("FAIL pwrup_start_done: got %0d pulses want 1", done_rises); else n_pass++;
        $display("test_start_in_pwrup: %0d writes, %0d done pulses", wq.size(), done_rises);
    endtask

    initial begin
        string msg;
        msg = "    Welcome!     Enter R. No. : ";
        for (int i = 0; i < 32; i++) mem[i] = msg[i];
        for (int i = 0; i < 4096; i++) hist[i] = 8'h00;
        test_reset();
        test_init("init");
        test_refresh();
        test_back_to_back();
        test_fetch_sample();
        test_reset_mid_write();
        test_start_in_pwrup();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_refresh_ctrl.md
LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 SHALL have parameter T_PWRUP, default 750000: power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter T_AS, default 4: cycles of RS/DB setup before E rises.
REQ-003 SHALL have parameter T_PW, default 12: cycles E is held high.
REQ-004 SHALL have parameter T_WAIT, default 2000: cycles after E falls before the next write (40 us).
REQ-005 SHALL have parameter T_CLR, default 82000: post-write wait used instead of T_WAIT after the clear command (1.64 ms).
REQ-006 clk  input  1  sole clock; all logic is rising-edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 start  input  1  single-cycle refresh request.
REQ-009 char_addr  output  5  character index driven to the 32-char string memory (line 1 = 0..15, line 2 = 16..31).
REQ-010 char_data  input  8  combinational ASCII byte returned for char_addr.
REQ-011 lcd_rs  output  1  0 = command, 1 = data.
REQ-012 lcd_rw  output  1  read/write select; tied 0.
REQ-013 lcd_e  output  1  LCD enable strobe.
REQ-014 lcd_db  output  8  LCD data bus.
REQ-015 busy  output  1  high during init or refresh.
REQ-016 done  output  1  one-cycle pulse when a refresh completes.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States SHALL be PWRUP, INIT, IDLE, SETADDR, FETCH, WRITE, DONE.
REQ-019 PWRUP SHALL count T_PWRUP cycles, then go to INIT.
REQ-020 INIT SHALL issue the commands 0x38, 0x0C, 0x06, 0x01 (RS=0) in that order, then go to IDLE.
REQ-021 Every write SHALL drive lcd_rs/lcd_db for T_AS cycles with E=0, then E=1 for T_PW cycles, then E=0 for T_WAIT cycles (T_CLR for 0x01); lcd_rs/lcd_db SHALL stay stable from setup start until E falls.
REQ-022 In IDLE, start (or a pending request) SHALL begin a refresh: command 0x80, data chars 0..15, command 0xC0, data chars 16..31 (34 writes total).
REQ-023 For each data write, char_addr SHALL be set in SETADDR, and char_data SHALL be sampled into lcd_db in the following FETCH cycle; later changes to char_data SHALL not affect that write.
REQ-024 char_addr SHALL increment 0..31 without wrap inside a refresh and SHALL hold 0 outside data fetches.
REQ-025 After the last write, DONE SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-026 start asserted while busy SHALL set a one-bit pending flag; multiple starts SHALL collapse into one pending refresh.
REQ-027 The pending refresh SHALL begin on the cycle after DONE.
REQ-028 start during PWRUP/INIT SHALL also be recorded as pending.
REQ-029 busy SHALL be 0 only in IDLE with no pending request.
REQ-030 Wait counters SHALL be wide enough for max(T_PWRUP, T_CLR) and SHALL not overflow.

Reset
REQ-031 On rst_n=0 at a clk edge: state=PWRUP, counters=0, pending=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, char_addr=0, busy=1, done=0.
REQ-032 Reset mid-write SHALL drop lcd_e at that same edge, and the full power-up/init sequence SHALL rerun.

Structure
REQ-033 Command bytes (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and state encodings SHALL live in shared package lcd_defs.
REQ-034 Write timing (REQ-021) SHALL be implemented in sub-module lcd_wr_phy with a req/rs/data/long_wait in, ready out handshake; the top FSM issues a req only when ready=1.

Verification (T_PWRUP=10, T_AS=1, T_PW=2, T_WAIT=3, T_CLR=20)
REQ-035 Release reset -> after 10 cycles, 4 E pulses with RS=0 and DB 0x38, 0x0C, 0x06, 0x01; 20-cycle gap after 0x01; busy falls.
REQ-036 Memory holds "    Welcome!     Enter R. No. : ", start -> 34 pulses: 0x80, 0x20 x4, 0x57 'W' ..., 0xC0, ..., 0x20 last; done high exactly 1 cycle.
REQ-037 Three start pulses during a refresh -> exactly one further refresh immediately after done, then IDLE.
REQ-038 rst_n low while lcd_e=1 at char 7 -> lcd_e=0 at that edge, then the power-up wait and 4 init commands repeat.
REQ-039 char_data toggled every cycle -> each written byte equals the value present in its FETCH cycle; lcd_rw stays 0 throughout.
